// File: rtl/mux_sel_pkg.sv
// Shared types and default constants for the mux select debouncer.
package mux_sel_pkg;

  localparam int OP_W            = 4;
  localparam int DEF_DB_CYCLES   = 1_000_000;
  localparam int DEF_CNT_W       = 20;
  localparam int DEF_AUTO_CYCLES = 25_000_000;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level, with a configurable reset value.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/mux_sel_debouncer.sv
// Debounces the active-low key; each qualified press toggles s and latches x/y together.
// Optional periodic auto-toggle is enabled with `define AUTO_TOGGLE_EN.
module mux_sel_debouncer
  import mux_sel_pkg::*;
#(
  parameter int DB_CYCLES   = DEF_DB_CYCLES,
`ifdef AUTO_TOGGLE_EN
  parameter int AUTO_CYCLES = DEF_AUTO_CYCLES,
`endif
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            key_n,
`ifdef AUTO_TOGGLE_EN
  input  logic            auto_en,
`endif
  input  logic [OP_W-1:0] x_sw,
  input  logic [OP_W-1:0] y_sw,
  output logic [OP_W-1:0] x,
  output logic [OP_W-1:0] y,
  output logic            s,
  output logic            press
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             key_s;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             btn_fire;
  logic             action;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (key_n),
    .q   (key_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RELEASED;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // The counter is cleared on every state change so it never wraps.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    btn_fire  = 1'b0;
    case (state)
      RELEASED: begin
        cnt_nxt = '0;
        if (!key_s) state_nxt = PRESS_WAIT;
      end
      PRESS_WAIT: begin
        if (key_s) begin
          state_nxt = RELEASED;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
          btn_fire  = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      HELD: begin
        cnt_nxt = '0;
        if (key_s) state_nxt = RELEASE_WAIT;
      end
      RELEASE_WAIT: begin
        if (!key_s) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = RELEASED;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = RELEASED;
        cnt_nxt   = '0;
      end
    endcase
  end

`ifdef AUTO_TOGGLE_EN
  localparam int AUTO_W = (AUTO_CYCLES > 1) ? $clog2(AUTO_CYCLES) : 1;
  localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_CYCLES - 1);

  logic [AUTO_W-1:0] per_cnt;
  logic              auto_fire;

  assign auto_fire = auto_en && (per_cnt == AUTO_LAST);
  // A coincident press and expiry merge into one action.
  assign action    = btn_fire | auto_fire;

  always_ff @(posedge clk) begin
    if (rst || !auto_en || action) begin
      per_cnt <= '0;
    end else begin
      per_cnt <= per_cnt + 1'b1;
    end
  end
`else
  assign action = btn_fire;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      x     <= '0;
      y     <= '0;
      s     <= 1'b0;
      press <= 1'b0;
    end else begin
      press <= action;
      if (action) begin
        s <= ~s;
        x <= x_sw;
        y <= y_sw;
      end
    end
  end

endmodule

// File: tb/tb_mux_sel_debouncer.sv
// Self-checking bench for mux_sel_debouncer: vector table, directed corner cases,
// and randomized key/switch activity against a run-length reference model.
module tb_mux_sel_debouncer;
  import mux_sel_pkg::*;

  localparam int DB   = 4;
  localparam int AUTO = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_n = 1'b1;
  logic       auto_en = 1'b0;
  logic [3:0] x_sw = 4'h0;
  logic [3:0] y_sw = 4'h0;
  logic [3:0] x, y;
  logic       s, press;

  int n_cmp = 0;
  int n_bad = 0;
  int n_press = 0;

  always #5 clk = ~clk;

  mux_sel_debouncer #(
    .DB_CYCLES   (DB),
`ifdef AUTO_TOGGLE_EN
    .AUTO_CYCLES (AUTO),
`endif
    .CNT_W       (3)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .key_n   (key_n),
`ifdef AUTO_TOGGLE_EN
    .auto_en (auto_en),
`endif
    .x_sw    (x_sw),
    .y_sw    (y_sw),
    .x       (x),
    .y       (y),
    .s       (s),
    .press   (press)
  );

  // Reference model: key passes two sync stages, then the debounced level flips
  // once the synchronised key has held a new value for DB+1 consecutive samples.
  logic       m_s1, m_s2, m_run_val, m_db;
  int         m_run_len, m_since;
  logic       m_s, m_press;
  logic [3:0] m_x, m_y;

  task automatic model_tick();
    logic ks, btn, fire;
    if (rst) begin
      m_s1 = 1'b1; m_s2 = 1'b1; m_run_val = 1'b1; m_run_len = DB + 1; m_db = 1'b1;
      m_s = 1'b0; m_x = 4'h0; m_y = 4'h0; m_press = 1'b0; m_since = 0;
    end else begin
      ks = m_s2;
      m_s2 = m_s1;
      m_s1 = key_n;
      if (ks == m_run_val) m_run_len++;
      else begin
        m_run_val = ks;
        m_run_len = 1;
      end
      btn = 1'b0;
      if (ks != m_db && m_run_len >= DB + 1) begin
        m_db = ks;
        btn  = !ks;
      end
      fire = btn || (auto_en && m_since == AUTO - 1);
      if (!auto_en || fire) m_since = 0;
      else m_since++;
      m_press = fire;
      if (fire) begin
        m_s = ~m_s;
        m_x = x_sw;
        m_y = y_sw;
      end
    end
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic kn, input logic [3:0] xs, input logic [3:0] ys);
    rst = r; key_n = kn; x_sw = xs; y_sw = ys;
    @(posedge clk);
    model_tick();
    #1;
    check("model_x", x, m_x);
    check("model_y", y, m_y);
    check("model_s", {3'b0, s}, {3'b0, m_s});
    check("model_press", {3'b0, press}, {3'b0, m_press});
    if (press === 1'b1) n_press++;
  endtask

  task automatic do_reset();
    step(1'b1, 1'b1, 4'h0, 4'h0);
    step(1'b1, 1'b1, 4'h0, 4'h0);
    n_press = 0;
  endtask

  typedef struct {
    logic       rst;
    logic       key_n;
    logic [3:0] xs;
    logic [3:0] ys;
    logic       press;
    logic       s;
    logic [3:0] x;
    logic [3:0] y;
  } vec_t;

  vec_t tbl[15];

  initial begin
    // Reset held 3 cycles with the key down, then the key stays down:
    // row 3+i is edge i after reset; the press lands in the cycle after edge DB+2.
    for (int i = 0; i < 3; i++) tbl[i] = '{1'b1, 1'b0, 4'h3, 4'hc, 1'b0, 1'b0, 4'h0, 4'h0};
    for (int i = 0; i < 12; i++) begin
      tbl[3+i] = '{1'b0, 1'b0, 4'h3, 4'hc, (i == DB + 2), (i >= DB + 2),
                   (i >= DB + 2) ? 4'h3 : 4'h0, (i >= DB + 2) ? 4'hc : 4'h0};
    end
    for (int i = 0; i < 15; i++) begin
      step(tbl[i].rst, tbl[i].key_n, tbl[i].xs, tbl[i].ys);
      check("tbl_press", {3'b0, press}, {3'b0, tbl[i].press});
      check("tbl_s", {3'b0, s}, {3'b0, tbl[i].s});
      check("tbl_x", x, tbl[i].x);
      check("tbl_y", y, tbl[i].y);
    end
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 4'h3, 4'hc);
    check("clean_one_pulse", 4'(n_press), 4'd1);

    // Bounce: too-short low runs never qualify.
    do_reset();
    step(1'b0, 1'b0, 4'h5, 4'ha);
    step(1'b0, 1'b0, 4'h5, 4'ha);
    step(1'b0, 1'b1, 4'h5, 4'ha);
    step(1'b0, 1'b0, 4'h5, 4'ha);
    step(1'b0, 1'b0, 4'h5, 4'ha);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 4'h5, 4'ha);
    check("bounce_pulses", 4'(n_press), 4'd0);
    check("bounce_s", {3'b0, s}, 4'd0);
    check("bounce_x", x, 4'h0);
    check("bounce_y", y, 4'h0);

    // Two presses with switch movement while held and while released.
    do_reset();
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 4'h3, 4'hc);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 4'hf, 4'hf);
    check("held_x", x, 4'h3);
    check("held_y", y, 4'hc);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 4'h9, 4'h6);
    check("release_s", {3'b0, s}, 4'd1);
    check("release_x", x, 4'h3);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 4'h0, 4'he);
    check("two_s", {3'b0, s}, 4'd0);
    check("two_x", x, 4'h0);
    check("two_y", y, 4'he);
    check("two_pulses", 4'(n_press), 4'd2);

    // Reset in the middle of the press debounce.
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 4'h7, 4'h7);
    step(1'b1, 1'b0, 4'h7, 4'h7);
    check("midrst_state", {2'b0, dut.state}, {2'b0, RELEASED});
    check("midrst_s", {3'b0, s}, 4'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4'h7, 4'h7);
    check("midrst_pulses", 4'(n_press), 4'd0);
    check("midrst_x", x, 4'h0);

`ifdef AUTO_TOGGLE_EN
    // Auto-toggle alone: expiries at edges 15 and 31 after enabling.
    do_reset();
    auto_en = 1'b1;
    for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 4'h1, 4'h2);
    check("auto_pulses", 4'(n_press), 4'd2);
    check("auto_s", {3'b0, s}, 4'd0);
    // Press qualifying at edge 15 coincides with the expiry: one toggle.
    do_reset();
    auto_en = 1'b1;
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 4'h4, 4'h8);
    for (int i = 9; i < 20; i++) step(1'b0, 1'b0, 4'h4, 4'h8);
    check("coinc_pulses", 4'(n_press), 4'd1);
    check("coinc_s", {3'b0, s}, 4'd1);
    auto_en = 1'b0;
`endif

    // Randomized runs of key levels, switch changes and occasional resets.
    do_reset();
    for (int r = 0; r < 400; r++) begin
      logic       kn, rr;
      logic [3:0] xs, ys;
      int         len;
      kn  = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 9);
      xs  = 4'($urandom);
      ys  = 4'($urandom);
`ifdef AUTO_TOGGLE_EN
      if ($urandom_range(0, 7) == 0) auto_en = ~auto_en;
`endif
      for (int i = 0; i < len; i++) begin
        rr = ($urandom_range(0, 199) == 0);
        step(rr, kn, xs, ys);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
